// File: rtl/load_store_unit_pkg.sv
// Shared constants, state encoding and request legality check for the load/store unit.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} lsu_state_t;

    // Unsigned variants only make sense for loads; alignment follows access size.
    function automatic logic req_illegal(input logic we, input logic [2:0] f3,
                                         input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_BU:   bad = we;
            F3_H:    bad = off[0];
            F3_HU:   bad = we | off[0];
            F3_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle of the load/store unit.
interface load_store_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              misaligned;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, misaligned
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, misaligned
    );
endinterface

// File: rtl/load_store_unit_lanes.sv
// Byte/half lane extraction for loads and lane merge for sub-word stores.
module lsu_lanes
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic [31:0] store_merge
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = offset[1] ? word[31:16] : word[15:0];

        load_ext = word;
        case (funct3)
            F3_B:    load_ext = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_ext = {24'h0, byte_sel};
            F3_H:    load_ext = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_ext = {16'h0, half_sel};
            default: load_ext = word;
        endcase

        store_merge = word;
        case (funct3)
            F3_B: store_merge[{offset, 3'b000} +: 8] = wdata[7:0];
            F3_H: begin
                if (offset[1]) store_merge[31:16] = wdata[15:0];
                else           store_merge[15:0]  = wdata[15:0];
            end
            default: store_merge = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Turns byte/half/word loads and stores into aligned word accesses; sub-word stores are read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  core,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    input  logic [31:0]       mem_rdata
);
    lsu_state_t        state;
    logic              we_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merged_q;
    logic              err_q;
    logic [31:0]       rdata_q;
    logic [31:0]       load_ext;
    logic [31:0]       store_merge;
    logic              illegal;

    assign illegal = req_illegal(core.req_we, core.req_funct3, core.req_addr[1:0]);

    lsu_lanes u_lanes (
        .word        (mem_rdata),
        .offset      (addr_q[1:0]),
        .funct3      (f3_q),
        .wdata       (wdata_q),
        .load_ext    (load_ext),
        .store_merge (store_merge)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            we_q     <= 1'b0;
            f3_q     <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            merged_q <= 32'h0;
            err_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (core.req_valid) begin
                        we_q    <= core.req_we;
                        f3_q    <= core.req_funct3;
                        addr_q  <= core.req_addr;
                        wdata_q <= core.req_wdata;
                        err_q   <= illegal;
                        if (illegal) begin
                            rdata_q <= 32'h0;
                            state   <= RESP;
                        end else begin
                            state   <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (!we_q) begin
                        rdata_q <= load_ext;
                        state   <= RESP;
                    end else if (f3_q == F3_W) begin
                        state   <= RESP;
                    end else begin
                        merged_q <= store_merge;
                        state    <= WRITE;
                    end
                end
                WRITE:   state <= RESP;
                default: state <= IDLE;
            endcase
        end
    end

    // Memory side is decoded from state so reset immediately silences it.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = 32'h0;
        mem_we    = 1'b0;
        if (state == ACCESS || state == WRITE)
            mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
        if (state == ACCESS && we_q && f3_q == F3_W) begin
            mem_wdata = wdata_q;
            mem_we    = !rst;
        end else if (state == WRITE) begin
            mem_wdata = merged_q;
            mem_we    = !rst;
        end
    end

    assign core.req_ready  = (state == IDLE);
    assign core.rsp_valid  = (state == RESP);
    assign core.misaligned = (state == RESP) && err_q;
    assign core.rsp_rdata  = rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit against a small word memory with combinational read.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk;
    logic        rst;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;
    logic [31:0] mem [0:255];
    logic        mem_init;

    int n_chk = 0;
    int n_err = 0;

    typedef struct packed {
        logic        mis;
        logic [31:0] rdata;
    } rsp_t;
    rsp_t sb_q[$];

    load_store_unit_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .core      (bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    always @(posedge clk) begin
        if (mem_init)    mem[250] <= 32'hDEADBEEF;
        else if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request; we_cyc is the cycle after accept where mem_we must fire (0 = never).
    task automatic do_req(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input logic exp_mis,
                          input int exp_lat, input int we_cyc, input logic [31:0] exp_wd);
        rsp_t exp;
        bit   got;
        sb_q.push_back({exp_mis, exp_rd});
        @(negedge clk);
        chk({tag, ".ready"}, {31'h0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_wdata  = 32'h0;
        got = 1'b0;
        for (int k = 1; k <= 8 && !got; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.req_ready) chk({tag, ".busy"}, k, 32'd0);
            if (mem_we) begin
                chk({tag, ".we_cyc"}, k, we_cyc);
                chk({tag, ".wdata"}, mem_wdata, exp_wd);
            end
            if (bus.rsp_valid) begin
                got = 1'b1;
                chk({tag, ".lat"}, k, exp_lat);
                if (sb_q.size() == 0) begin
                    chk({tag, ".sb_empty"}, 32'd0, 32'd1);
                end else begin
                    exp = sb_q.pop_front();
                    chk({tag, ".rdata"}, bus.rsp_rdata, exp.rdata);
                    chk({tag, ".mis"}, {31'h0, bus.misaligned}, {31'h0, exp.mis});
                end
            end
        end
        if (!got) chk({tag, ".timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        rst      = 1'b1;
        mem_init = 1'b1;
        repeat (2) @(negedge clk);
        mem_init = 1'b0;
        chk("rst.ready", {31'h0, bus.req_ready}, 32'd1);
        chk("rst.rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
        chk("rst.mis", {31'h0, bus.misaligned}, 32'd0);
        chk("rst.rdata", bus.rsp_rdata, 32'h0);
        chk("rst.mem_we", {31'h0, mem_we}, 32'd0);
        chk("rst.mem_addr", mem_addr, 32'h0);
        chk("rst.mem_wdata", mem_wdata, 32'h0);
        rst = 1'b0;

        do_req("lb",   1'b0, F3_B,  32'h3E9, 32'h0, 32'hFFFFFFBE, 1'b0, 2, 0, 32'h0);
        do_req("lbu",  1'b0, F3_BU, 32'h3E9, 32'h0, 32'h000000BE, 1'b0, 2, 0, 32'h0);
        do_req("lh",   1'b0, F3_H,  32'h3EA, 32'h0, 32'hFFFFDEAD, 1'b0, 2, 0, 32'h0);
        do_req("lhu",  1'b0, F3_HU, 32'h3EA, 32'h0, 32'h0000DEAD, 1'b0, 2, 0, 32'h0);
        do_req("lhu0", 1'b0, F3_HU, 32'h3E8, 32'h0, 32'h0000BEEF, 1'b0, 2, 0, 32'h0);
        do_req("sb",   1'b1, F3_B,  32'h3EB, 32'h12345677, 32'h0000BEEF, 1'b0, 3, 2, 32'h77ADBEEF);
        do_req("lw1",  1'b0, F3_W,  32'h3E8, 32'h0, 32'h77ADBEEF, 1'b0, 2, 0, 32'h0);
        do_req("sw",   1'b1, F3_W,  32'h3E8, 32'hCAFEF00D, 32'h77ADBEEF, 1'b0, 2, 1, 32'hCAFEF00D);
        do_req("lw2",  1'b0, F3_W,  32'h3E8, 32'h0, 32'hCAFEF00D, 1'b0, 2, 0, 32'h0);
        do_req("sh",   1'b1, F3_H,  32'h3E8, 32'h00001234, 32'hCAFEF00D, 1'b0, 3, 2, 32'hCAFE1234);
        do_req("lw3",  1'b0, F3_W,  32'h3E8, 32'h0, 32'hCAFE1234, 1'b0, 2, 0, 32'h0);

        do_req("ill_sh",  1'b1, F3_H,   32'h3E9, 32'h0000AAAA, 32'h0, 1'b1, 1, 0, 32'h0);
        do_req("ill_lw",  1'b0, F3_W,   32'h3EA, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
        do_req("lw4",     1'b0, F3_W,   32'h3E8, 32'h0, 32'hCAFE1234, 1'b0, 2, 0, 32'h0);
        do_req("ill_f3",  1'b0, 3'b011, 32'h3E8, 32'h0, 32'h0, 1'b1, 1, 0, 32'h0);
        do_req("ill_sbu", 1'b1, F3_BU,  32'h3E8, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 0, 32'h0);
        chk("ill.mem", mem[250], 32'hCAFE1234);

        // Abort a byte store with reset during its write cycle.
        @(negedge clk);
        mem_init = 1'b1;
        @(negedge clk);
        mem_init = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = F3_B;
        bus.req_addr   = 32'h3E8;
        bus.req_wdata  = 32'h00000055;
        @(negedge clk);
        bus.req_valid = 1'b0;
        chk("abort.access_we", {31'h0, mem_we}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.we_gated", {31'h0, mem_we}, 32'd0);
        chk("abort.no_rsp", {31'h0, bus.rsp_valid}, 32'd0);
        @(negedge clk);
        chk("abort.ready", {31'h0, bus.req_ready}, 32'd1);
        chk("abort.rsp_valid", {31'h0, bus.rsp_valid}, 32'd0);
        chk("abort.rdata", bus.rsp_rdata, 32'h0);
        chk("abort.mem_we", {31'h0, mem_we}, 32'd0);
        chk("abort.mem_addr", mem_addr, 32'h0);
        chk("abort.mem_wdata", mem_wdata, 32'h0);
        chk("abort.mem", mem[250], 32'hDEADBEEF);
        rst = 1'b0;
        do_req("lw5", 1'b0, F3_W, 32'h3E8, 32'h0, 32'hDEADBEEF, 1'b0, 2, 0, 32'h0);
        chk("sb.drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
